// File: rtl/treasure_serial_tx_if.sv
// treasure_serial_tx_if: result capture, SIG request and serial output signals of the treasure transmitter.
interface treasure_serial_tx_if #(parameter int COLOR_W = 2, parameter int SHAPE_W = 2);
  logic [7:0] RESULT;
  logic colorFinished;
  logic [SHAPE_W-1:0] shape;
  logic shapeFinished;
  logic SIG;
  logic DATA;
  logic [SHAPE_W+COLOR_W-1:0] SHAPE_DATA;
  logic FRAME_DONE;
  logic [7:0] BIT_IDX;
  modport master (output RESULT, colorFinished, shape, shapeFinished, SIG,
                  input DATA, SHAPE_DATA, FRAME_DONE, BIT_IDX);
  modport slave (input RESULT, colorFinished, shape, shapeFinished, SIG,
                 output DATA, SHAPE_DATA, FRAME_DONE, BIT_IDX);
endinterface

// File: rtl/treasure_serial_tx.sv
// treasure_serial_tx: SIG-paced serial sender of the latest {shape, color} result.
// Frames are marker + payload (+ parity) per copy, REPEATS copies, then GAP_BITS zeros.
module treasure_serial_tx #(
  parameter int COLOR_W = 2,
  parameter int SHAPE_W = 2,
  parameter int REPEATS = 2,
  parameter int GAP_BITS = 1,
  parameter int PARITY_EN = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic CLK,
  input logic RST_N,
  treasure_serial_tx_if.slave bus
);
  localparam int P = SHAPE_W + COLOR_W;
  localparam int L = REPEATS * (1 + P + PARITY_EN) + GAP_BITS;
  typedef enum logic [2:0] {IDLE, MARK, PAY, PAR, GAP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sig_sync_q, sig_sync_d;
  logic sig_prev_q, sig_prev_d, color_prev_q, color_prev_d, shape_prev_q, shape_prev_d;
  logic [P-1:0] shape_data_q, shape_data_d, snap_q, snap_d, sh_q, sh_d;
  logic [7:0] rep_q, rep_d, cnt_q, cnt_d, idx_q, idx_d;
  logic data_q, data_d, frame_done_q, frame_done_d;
  logic req, new_frame, end_copy;
  always_comb begin
    color_prev_d = bus.colorFinished;
    shape_prev_d = bus.shapeFinished;
    shape_data_d = {bus.shapeFinished & ~shape_prev_q ? bus.shape : shape_data_q[P-1:COLOR_W],
                    bus.colorFinished & ~color_prev_q ? bus.RESULT[COLOR_W-1:0] : shape_data_q[COLOR_W-1:0]};
    sig_sync_d = {sig_sync_q[SYNC_STAGES-2:0], bus.SIG};
    sig_prev_d = sig_sync_q[SYNC_STAGES-1];
    req = sig_sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    state_d = state_q;
    snap_d = snap_q;
    sh_d = sh_q;
    rep_d = rep_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    data_d = data_q;
    new_frame = 1'b0;
    end_copy = 1'b0;
    if (req) begin
      idx_d = idx_q + 8'd1;
      case (state_q)
        MARK: begin
          state_d = PAY;
          data_d = snap_q[P-1];
          sh_d = snap_q << 1;
          cnt_d = 8'd1;
        end
        PAY: begin
          if (cnt_q < 8'(P)) begin
            data_d = sh_q[P-1];
            sh_d = sh_q << 1;
            cnt_d = cnt_q + 8'd1;
          end else if (PARITY_EN != 0) begin
            state_d = PAR;
            data_d = ^snap_q;
          end else end_copy = 1'b1;
        end
        PAR: end_copy = 1'b1;
        GAP: begin
          if (cnt_q < 8'(GAP_BITS)) cnt_d = cnt_q + 8'd1;
          else new_frame = 1'b1;
        end
        default: new_frame = 1'b1;
      endcase
      if (end_copy) begin
        if (rep_q < 8'(REPEATS - 1)) begin
          state_d = MARK;
          rep_d = rep_q + 8'd1;
          data_d = 1'b1;
        end else if (GAP_BITS > 0) begin
          state_d = GAP;
          cnt_d = 8'd1;
          data_d = 1'b0;
        end else new_frame = 1'b1;
      end
      // The snapshot takes the held value from before any same-cycle strobe update.
      if (new_frame) begin
        state_d = MARK;
        snap_d = shape_data_q;
        rep_d = 8'd0;
        idx_d = 8'd0;
        data_d = 1'b1;
      end
    end
    frame_done_d = req && idx_d == 8'(L - 1);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sig_sync_q <= '1;
      sig_prev_q <= 1'b1;
      color_prev_q <= 1'b0;
      shape_prev_q <= 1'b0;
      shape_data_q <= '0;
      snap_q <= '0;
      sh_q <= '0;
      rep_q <= 8'd0;
      cnt_q <= 8'd0;
      idx_q <= 8'd0;
      data_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_sync_q <= sig_sync_d;
      sig_prev_q <= sig_prev_d;
      color_prev_q <= color_prev_d;
      shape_prev_q <= shape_prev_d;
      shape_data_q <= shape_data_d;
      snap_q <= snap_d;
      sh_q <= sh_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      data_q <= data_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign bus.DATA = data_q;
  assign bus.SHAPE_DATA = shape_data_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.BIT_IDX = idx_q;
endmodule

// File: tb/tb_treasure_serial_tx.sv
// tb_treasure_serial_tx: default and parity-enabled transmitters driven side by side,
// compared against a frame-level model built from the frame layout rules.
module tb_treasure_serial_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] result = 8'h00;
  logic cfin = 1'b0;
  logic [1:0] shp = 2'b00;
  logic sfin = 1'b0;
  logic sig = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_sd = 4'h0;
  int pos [2] = '{-1, -1};
  logic [3:0] snap [2] = '{4'h0, 4'h0};
  int len [2] = '{11, 13};
  int pe [2] = '{0, 1};
  always #5 clk = ~clk;
  treasure_serial_tx_if #(.COLOR_W(2), .SHAPE_W(2)) b0 ();
  treasure_serial_tx_if #(.COLOR_W(2), .SHAPE_W(2)) b1 ();
  assign b0.RESULT = result;
  assign b0.colorFinished = cfin;
  assign b0.shape = shp;
  assign b0.shapeFinished = sfin;
  assign b0.SIG = sig;
  assign b1.RESULT = result;
  assign b1.colorFinished = cfin;
  assign b1.shape = shp;
  assign b1.shapeFinished = sfin;
  assign b1.SIG = sig;
  treasure_serial_tx dut0 (.CLK(clk), .RST_N(rst_n), .bus(b0));
  treasure_serial_tx #(.PARITY_EN(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Bit p of a frame: each copy is marker 1, payload MSB-first, optional parity; gap zeros follow.
  function automatic logic exp_bit(input logic [3:0] s, input int p, input int e);
    int c = 5 + e;
    int k = p % c;
    if (p >= 2 * c) return 1'b0;
    if (k == 0) return 1'b1;
    if (k <= 4) return s[4-k];
    return ^s;
  endfunction
  task automatic check_one(input string tag, input int i, input logic d, input logic [7:0] idx, input logic done, input logic [3:0] sd);
    chk({tag, "_data"}, 32'(d), pos[i] < 0 ? 32'd1 : 32'(exp_bit(snap[i], pos[i], pe[i])));
    chk({tag, "_idx"}, 32'(idx), pos[i] < 0 ? 32'd0 : 32'(pos[i]));
    chk({tag, "_done"}, 32'(done), 32'(pos[i] == len[i] - 1));
    chk({tag, "_sd"}, 32'(sd), 32'(m_sd));
  endtask
  task automatic check_outs(input string tag);
    check_one({tag, "0"}, 0, b0.DATA, b0.BIT_IDX, b0.FRAME_DONE, b0.SHAPE_DATA);
    check_one({tag, "1"}, 1, b1.DATA, b1.BIT_IDX, b1.FRAME_DONE, b1.SHAPE_DATA);
  endtask
  task automatic pulse(input int hi, input int lo, input bit sc, input logic [7:0] cv);
    @(negedge clk) sig = 1'b1;
    repeat (2) @(negedge clk);
    if (sc) begin
      result = cv;
      cfin = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pos[i] < 0 || pos[i] == len[i] - 1) begin
        pos[i] = 0;
        snap[i] = m_sd;
      end else pos[i]++;
    end
    if (sc) begin
      m_sd[1:0] = cv[1:0];
      cfin = 1'b0;
    end
    check_outs("bit");
    repeat (hi - 3) @(negedge clk);
    sig = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  task automatic strobe(input bit dc, input logic [7:0] cv, input bit ds, input logic [1:0] sv, input int n);
    @(negedge clk);
    result = cv;
    shp = sv;
    cfin = dc;
    sfin = ds;
    if (dc) m_sd[1:0] = cv[1:0];
    if (ds) m_sd[3:2] = sv;
    repeat (n) begin
      @(negedge clk);
      result = 8'($urandom);
      shp = 2'($urandom);
    end
    cfin = 1'b0;
    sfin = 1'b0;
    @(negedge clk);
    chk("strobe_sd0", 32'(b0.SHAPE_DATA), 32'(m_sd));
    chk("strobe_sd1", 32'(b1.SHAPE_DATA), 32'(m_sd));
  endtask
  task automatic pulses_until(input int target);
    for (int n = 0; n < 12 && pos[0] != target; n++) pulse(3, 3, 1'b0, 8'h00);
    chk("reach_pos", 32'(pos[0]), 32'(target));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("reset");
    strobe(1'b1, 8'hF1, 1'b1, 2'b10, 1);
    chk("capture_1001", 32'(b0.SHAPE_DATA), 32'h9);
    repeat (12) pulse(3, 3, 1'b0, 8'h00);
    repeat (2) pulse(3, 3, 1'b0, 8'h00);
    strobe(1'b1, 8'h02, 1'b0, 2'b00, 1);
    repeat (20) pulse(4, 3, 1'b0, 8'h00);
    pulses_until(10);
    pulse(3, 3, 1'b1, 8'h03);
    repeat (12) pulse(3, 4, 1'b0, 8'h00);
    pulses_until(6);
    @(negedge clk);
    rst_n = 1'b0;
    sig = 1'b1;
    #1;
    chk("async_data0", 32'(b0.DATA), 32'd1);
    chk("async_data1", 32'(b1.DATA), 32'd1);
    chk("async_idx0", 32'(b0.BIT_IDX), 32'd0);
    pos = '{-1, -1};
    m_sd = 4'h0;
    cfin = 1'b0;
    sfin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_outs("sig_held");
    sig = 1'b0;
    repeat (4) @(negedge clk);
    pulse(3, 3, 1'b0, 8'h00);
    strobe(1'b1, 8'hA7, 1'b0, 2'b00, 20);
    chk("held_strobe", 32'(b0.SHAPE_DATA[1:0]), 32'h3);
    for (int it = 0; it < 300; it++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 7) pulse(int'($urandom_range(3, 5)), int'($urandom_range(3, 5)), r == 0, 8'($urandom));
      else if (r < 9) strobe(1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(1, 3)));
      else repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/treasure_serial_tx.md
# treasure_serial_tx

Parametrised, SIG-clocked serial transmitter that ships the latest treasure result (color + shape) to the Arduino over one data line. Color and shape fields are captured independently from the image processor's finish strobes. A consistent snapshot is taken at each frame start. The Arduino pulls bits by raising SIG; the block oversamples SIG on the system clock. Each frame carries a marker, optional parity, REPEATS copies of the payload and a trailing gap, replacing the fixed 11-step SIG-edge-clocked sender.

## Interface
- COLOR_W, 2, width of the color field taken from RESULT LSBs (1..8)
- SHAPE_W, 2, width of the shape field
- REPEATS, 2, payload copies per frame (≥1)
- GAP_BITS, 1, zero bits appended after the last copy (≥0)
- PARITY_EN, 0, 1 = even-parity bit after each payload copy
- SYNC_STAGES, 2, SIG synchroniser depth (≥2)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- RESULT  in  8  image-processor result; bits [COLOR_W-1:0] are color
- colorFinished  in  1  color-ready level/pulse, synchronous to CLK
- shape  in  SHAPE_W  shape code
- shapeFinished  in  1  shape-ready level/pulse, synchronous to CLK
- SIG  in  1  Arduino bit-request line, asynchronous
- DATA  out  1  serial data to Arduino, idle high
- SHAPE_DATA  out  SHAPE_W+COLOR_W  held result {shape, color}
- FRAME_DONE  out  1  one-cycle pulse when last frame bit is driven
- BIT_IDX  out  8  index of bit currently on DATA (0 = marker)

## Operation
- P = SHAPE_W+COLOR_W. Copy length C = 1+P+PARITY_EN. Frame length L = REPEATS*C+GAP_BITS (default 11).
- Field capture: rising edge of colorFinished (in=1, prev=0) loads SHAPE_DATA[COLOR_W-1:0] <= RESULT[COLOR_W-1:0]. Rising edge of shapeFinished loads SHAPE_DATA[P-1:COLOR_W] <= shape. Simultaneous edges update both fields. A held-high strobe updates once only.
- SIG path: SYNC_STAGES flops, then a prev flop. A bit request is sync_out=1 with prev=0.
- FSM states:
  - IDLE: DATA=1.
  - MARK: DATA=1.
  - PAY: payload bits MSB-first from snapshot.
  - PAR: XOR of snapshot, only when PARITY_EN.
  - GAP: DATA=0.
- Transitions, each on one bit request:
  - IDLE→MARK, taking the snapshot.
  - MARK→PAY.
  - PAY advances through P bits, then →PAR (PARITY_EN) or →next copy.
  - After copy r<REPEATS, next request →MARK. Same snapshot, no re-capture.
  - After last copy →GAP (GAP_BITS>0), else the frame ends.
  - After last GAP bit, next request →MARK with a new snapshot. The stream is continuous and there is no return to IDLE.
- Snapshot = SHAPE_DATA value before any same-cycle field update. Field updates never alter a frame in flight.
- BIT_IDX counts 0..L-1 within a frame and wraps to 0 at the next MARK. It reads 0 in IDLE.
- FRAME_DONE is high for exactly the cycle the frame's bit L-1 is loaded onto DATA.

## Timing
- Reset (async assert): DATA=1, SHAPE_DATA=0, FRAME_DONE=0, BIT_IDX=0, state IDLE, strobe prev flops 0. SIG sync and prev flops reset to 1, so SIG already high at release is not a request.
- Reset mid-frame: DATA goes to 1 immediately and the frame is discarded. The first request after release starts a fresh frame with a fresh snapshot.
- SIG→DATA latency: DATA changes on the (SYNC_STAGES+1)th CLK edge after SIG rises (3 cycles default). BIT_IDX and FRAME_DONE are updated on the same edge.
- SIG high and low phases must each be ≥ SYNC_STAGES+1 CLK periods. Shorter pulses are not guaranteed.
- Strobe→SHAPE_DATA: visible after the first CLK edge sampling the strobe high (1 cycle).
- A strobe edge in the same cycle as a MARK request updates SHAPE_DATA. The snapshot carries the old value and the new value goes out in the next frame.
- No requests means DATA holds its current bit indefinitely.

## Test plan
- Defaults. Reset, shape=2'b10 + shapeFinished pulse, RESULT=8'hF1 + colorFinished pulse → SHAPE_DATA=4'b1001. Then 11 SIG pulses → DATA 1,1,0,0,1,1,1,0,0,1,0. FRAME_DONE on pulse 11. 12th pulse → DATA=1, BIT_IDX=0.
- PARITY_EN=1, SHAPE_DATA=4'b1011 → per copy 1,1,0,1,1,1. L=13, gap 0 last.
- Update mid-frame. After pulse 3 set color=2'b10 → remaining bits of the frame are unchanged. The next frame carries 4'b1010. Simultaneous strobe and MARK cycle → old value sent.
- SIG held high across RST_N release → no bit advance, DATA=1. A 2-cycle SIG glitch with SYNC_STAGES=2 is not required to register; a 3-cycle pulse must.
- Reset asserted at BIT_IDX=6 → DATA=1 asynchronously. After release, the next pulse gives marker 1 with BIT_IDX=0.
- colorFinished held high 20 cycles while RESULT changes → SHAPE_DATA takes the RESULT value of the first high cycle only.
